// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults and ABI register indices for the scoreboarded register file
// Contents: default geometry (data width, register count, address width),
//           the hardwired zero register index, and ABI indices used by debug monitors.
package regfile_sb_pkg;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_REG_NUM     = 32;
   localparam int DEF_REG_NUM_BIT = 5;
   localparam int ZERO_REG        = 0;
   localparam int SP              = 2;
   localparam int A4              = 14;
   localparam int A5              = 15;
endpackage

// File: rtl/regfile_sb_counter.sv
// sb_counter: pending-write up/down counter for one architectural register
// Ports: clk, rst (async, active-high), inc/dec (simultaneous pair cancels),
//        clr (sync clear, priority over inc/dec), cnt (current count), sat (count at max).
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && !dec) cnt <= cnt + 1'b1;
      else if (dec && !inc) cnt <= cnt - 1'b1;
   assign sat = &cnt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with write-to-read bypass and per-register pending-write scoreboard
// Ports: clk, rst (async, active-high);
//        raddr/rdata/rbusy: NUM_RD packed combinational read ports with hazard flag;
//        wen/waddr/wdata: writeback port; iss_valid/iss_rd/iss_ready: decode issue handshake;
//        flush: discard all outstanding writes; sb_err: sticky scoreboard error.
module regfile_sb import regfile_sb_pkg::*; #(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int REG_NUM     = DEF_REG_NUM,
   parameter int REG_NUM_BIT = DEF_REG_NUM_BIT,
   parameter int NUM_RD      = 2,
   parameter int CNT_W       = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_RD*REG_NUM_BIT-1:0] raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0]  rdata,
   output logic [NUM_RD-1:0]             rbusy,
   input  logic                          wen,
   input  logic [REG_NUM_BIT-1:0]        waddr,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          iss_valid,
   input  logic [REG_NUM_BIT-1:0]        iss_rd,
   output logic                          iss_ready,
   input  logic                          flush,
   output logic                          sb_err
);
   logic [DATA_WIDTH-1:0] rf  [REG_NUM];
   logic [CNT_W-1:0]      cnt [REG_NUM];
   logic [REG_NUM-1:0]    sat;
   logic                  w_live, stray, bad_addr, drop;

   function automatic logic in_rng(input logic [REG_NUM_BIT-1:0] a);
      return int'(a) < REG_NUM;
   endfunction

   // Writes that actually land in the array: nonzero, in-range destination.
   assign w_live   = wen && waddr != REG_NUM_BIT'(ZERO_REG) && in_rng(waddr);
   // Stray writeback (nothing outstanding); a concurrent flush makes it legitimate.
   assign stray    = w_live && cnt[waddr] == '0 && !flush;
   assign bad_addr = wen && !in_rng(waddr);
   assign drop     = iss_valid && !iss_ready;

   always_ff @(posedge clk or posedge rst)
      if (rst) for (int r = 0; r < REG_NUM; r++) rf[r] <= '0;
      else if (w_live) rf[waddr] <= wdata;

   always_ff @(posedge clk or posedge rst)
      if (rst) sb_err <= 1'b0;
      else if (stray || bad_addr || drop) sb_err <= 1'b1;

   assign cnt[0] = '0;
   assign sat[0] = 1'b0;

   generate
      for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
         sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk(clk),
            .rst(rst),
            .inc(iss_valid && iss_ready && iss_rd == REG_NUM_BIT'(r)),
            .dec(wen && waddr == REG_NUM_BIT'(r) && cnt[r] != '0),
            .clr(flush),
            .cnt(cnt[r]),
            .sat(sat[r])
         );
      end
   endgenerate

   // A retire to the same register this cycle frees a saturated slot.
   assign iss_ready = rst || iss_rd == REG_NUM_BIT'(ZERO_REG) || !in_rng(iss_rd) ||
                      !sat[iss_rd] || (wen && waddr == iss_rd);

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [REG_NUM_BIT-1:0] ra;
         logic                   live, hit;
         assign ra   = raddr[i*REG_NUM_BIT +: REG_NUM_BIT];
         assign live = !rst && ra != REG_NUM_BIT'(ZERO_REG) && in_rng(ra);
         assign hit  = wen && waddr == ra;
         assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = !live ? '0 : hit ? wdata : rf[ra];
         // The arriving value only clears the hazard when it retires the last outstanding write.
         assign rbusy[i] = live && (cnt[ra] - CNT_W'(hit && cnt[ra] != '0)) != '0;
      end
   endgenerate
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven bench for regfile_sb plus hand-written scoreboard sequences
module tb_regfile_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        iss_ready;
   logic        flush;
   logic        sb_err;
   int          n_chk = 0;
   int          n_pass = 0;

   regfile_sb dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .iss_ready(iss_ready), .flush(flush), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  a0, a1;
      logic        iv;
      logic [4:0]  ird;
      logic [31:0] e0, e1;
      logic [1:0]  eb;
      logic        er;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
      else n_pass++;
   endtask

   task automatic idle();
      wen = 0; waddr = 0; wdata = 0; iss_valid = 0; iss_rd = 0; flush = 0; raddr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      raddr = {a1, a0};
   endtask

   task automatic pulse_rst();
      rst = 1; #1; rst = 0; #1;
   endtask

   initial begin
      idle();
      rst = 1;
      #1;
      chk("rst_rdata", rdata[31:0], 32'h0);
      chk("rst_busy", {30'b0, rbusy}, 32'h0);
      chk("rst_ready", {31'b0, iss_ready}, 32'h1);
      chk("rst_err", {31'b0, sb_err}, 32'h0);
      step();
      rst = 0;
      step();

      tv[0] = '{1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 2'b00, 0};
      tv[1] = '{1, 0, 32'h00001234, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 2'b00, 1};
      tv[2] = '{1, 7, 32'hA5A5A5A5, 7, 0, 0, 0, 32'hA5A5A5A5, 32'h0, 2'b00, 1};
      tv[3] = '{0, 0, 32'h0,        7, 5, 0, 0, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 1};
      tv[4] = '{0, 0, 32'h0,        3, 0, 1, 3, 32'h0, 32'h0, 2'b00, 1};
      tv[5] = '{0, 0, 32'h0,        3, 0, 1, 3, 32'h0, 32'h0, 2'b01, 1};
      tv[6] = '{1, 3, 32'h00000011, 3, 0, 0, 0, 32'h00000011, 32'h0, 2'b01, 1};
      tv[7] = '{1, 3, 32'h00000022, 3, 3, 0, 0, 32'h00000022, 32'h00000022, 2'b00, 1};
      tv[8] = '{0, 0, 32'h0,        3, 31, 0, 0, 32'h00000022, 32'h0, 2'b00, 1};
      for (int i = 0; i < 9; i++) begin
         wen = tv[i].wen; waddr = tv[i].waddr; wdata = tv[i].wdata;
         iss_valid = tv[i].iv; iss_rd = tv[i].ird; rd(tv[i].a0, tv[i].a1);
         #1;
         chk($sformatf("v%0d_rd0", i), rdata[31:0], tv[i].e0);
         chk($sformatf("v%0d_rd1", i), rdata[63:32], tv[i].e1);
         chk($sformatf("v%0d_busy", i), {30'b0, rbusy}, {30'b0, tv[i].eb});
         chk($sformatf("v%0d_ready", i), {31'b0, iss_ready}, 32'h1);
         chk($sformatf("v%0d_err", i), {31'b0, sb_err}, {31'b0, tv[i].er});
         step();
      end
      idle();
      rd(0, 3);
      #1;
      chk("x0_after_write", rdata[31:0], 32'h0);
      chk("x3_cnt_zero", {30'b0, rbusy}, 32'h0);

      pulse_rst();
      chk("sat_pre_err", {31'b0, sb_err}, 32'h0);
      iss_valid = 1; iss_rd = 4;
      for (int k = 0; k < 3; k++) step();
      rd(4, 0);
      #1;
      chk("sat_ready", {31'b0, iss_ready}, 32'h0);
      chk("sat_busy", {30'b0, rbusy}, 32'h1);
      step();
      chk("sat_drop_err", {31'b0, sb_err}, 32'h1);
      wen = 1; waddr = 4; wdata = 32'h77;
      #1;
      chk("sat_retire_ready", {31'b0, iss_ready}, 32'h1);
      chk("sat_retire_busy", {30'b0, rbusy}, 32'h1);
      chk("sat_retire_bypass", rdata[31:0], 32'h77);
      step();
      wen = 0;
      #1;
      chk("sat_still_full", {31'b0, iss_ready}, 32'h0);
      idle();

      pulse_rst();
      iss_valid = 1; iss_rd = 9;
      step(); step();
      iss_valid = 0;
      flush = 1; wen = 1; waddr = 9; wdata = 32'h55; rd(9, 0);
      #1;
      chk("flush_pre_busy", {30'b0, rbusy}, 32'h1);
      chk("flush_bypass", rdata[31:0], 32'h55);
      step();
      flush = 0; wen = 0;
      #1;
      chk("flush_data", rdata[31:0], 32'h55);
      chk("flush_busy", {30'b0, rbusy}, 32'h0);
      chk("flush_err", {31'b0, sb_err}, 32'h0);
      wen = 1; waddr = 9; wdata = 32'h66;
      step();
      wen = 0;
      #1;
      chk("post_flush_stray", {31'b0, sb_err}, 32'h1);
      chk("post_flush_data", rdata[31:0], 32'h66);
      idle();

      pulse_rst();
      for (int r = 1; r < 32; r++) begin
         wen = 1; waddr = 5'(r); wdata = r * 32'h01010101;
         step();
      end
      wen = 0; iss_valid = 1; iss_rd = 6;
      step();
      iss_valid = 0; rd(6, 31);
      #1;
      chk("pop_rd1", rdata[63:32], 32'h1F1F1F1F);
      chk("pop_rd0", rdata[31:0], 32'h06060606);
      chk("pop_busy", {30'b0, rbusy}, 32'h1);
      #2;
      rst = 1;
      #1;
      chk("arst_rd0", rdata[31:0], 32'h0);
      chk("arst_rd1", rdata[63:32], 32'h0);
      chk("arst_busy", {30'b0, rbusy}, 32'h0);
      chk("arst_err", {31'b0, sb_err}, 32'h0);
      #1;
      rst = 0;
      step();
      rd(6, 17);
      #1;
      chk("post_rst_x6", rdata[31:0], 32'h0);
      chk("post_rst_x17", rdata[63:32], 32'h0);
      chk("post_rst_busy", {30'b0, rbusy}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Next-generation NPC integer register file.
- Generalised in register count, data width and number of read ports.
- Adds write-to-read bypass, synchronous-free async reset of all architectural registers, and a per-register pending-write scoreboard (outstanding-write counters) that the decode stage uses to stall on RAW hazards.
- Sits between decode (read ports, issue) and writeback (write port) in the pipelined core.

Parameters:
- DATA_WIDTH, 32, bits per register.
- REG_NUM, 32, number of architectural registers; index 0 is hardwired zero.
- REG_NUM_BIT, 5, address width; must satisfy 2**REG_NUM_BIT >= REG_NUM.
- NUM_RD, 2, number of combinational read ports.
- CNT_W, 2, width of each pending-write counter; max outstanding writes per register = 2**CNT_W-1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- raddr  in  NUM_RD*REG_NUM_BIT  packed read addresses, port i at [i*REG_NUM_BIT +: REG_NUM_BIT].
- rdata  out  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rbusy  out  NUM_RD  port i source has an outstanding write not being resolved this cycle.
- wen  in  1  writeback write enable.
- waddr  in  REG_NUM_BIT  writeback destination.
- wdata  in  DATA_WIDTH  writeback data.
- iss_valid  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  REG_NUM_BIT  destination of the issued instruction.
- iss_ready  out  1  the issue would be accepted (counter of iss_rd not saturated).
- flush  in  1  discard all outstanding writes (pipeline squash).
- sb_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1, async): all registers 0; all counters 0; sb_err 0. rdata reads 0, rbusy 0, iss_ready 1 while reset is asserted.
- Register 0:
  - Writes are ignored. Reads return 0.
  - Never pending: issue to rd=0 is accepted, iss_ready=1, counter unchanged.
  - Writeback to 0 never affects counters.
- Write: on a clock edge with wen=1 and waddr!=0, rf[waddr] <= wdata. waddr >= REG_NUM is ignored and sets sb_err.
- Read (combinational, zero latency), per port i:
  - raddr_i==0 -> 0.
  - wen && waddr==raddr_i && waddr!=0 -> wdata (bypass).
  - Otherwise rf[raddr_i].
  - raddr_i >= REG_NUM -> 0.
- rbusy_i = (cnt[raddr_i] - dec_i) != 0, where dec_i = 1 if wen && waddr==raddr_i && raddr_i!=0.
  - A value arriving this cycle therefore unbusies the reader only when it is the last outstanding write.
- Counter update per register r != 0, each edge:
  - inc = iss_valid && iss_ready && iss_rd==r.
  - dec = wen && waddr==r && cnt[r]!=0.
  - inc && dec -> unchanged; inc only -> +1; dec only -> -1.
  - wen to a register with cnt==0 sets sb_err (stray writeback). The data write still occurs.
- iss_ready = (iss_rd==0) || cnt[iss_rd] != 2**CNT_W-1 || (wen && waddr==iss_rd).
  - A simultaneous retire frees the slot in the same cycle.
  - iss_valid while !iss_ready: issue dropped, counter unchanged, sb_err set.
- flush (synchronous, priority over iss/dec): all counters <= 0 at the edge. A wen in the same cycle still writes the data without raising sb_err. rbusy/iss_ready remain computed from pre-edge counters.
- sb_err clears only on rst.
- Reset mid-operation: state is cleared immediately. The first edge after rst deasserts behaves as from a cold start.

Decomposition:
- Shared package: DATA_WIDTH/REG_NUM/REG_NUM_BIT defaults, ZERO_REG constant, and the ABI index constants (SP=2, A4=14, A5=15) used by debug monitors.
- One sub-module, sb_counter: single CNT_W up/down counter with inc, dec, clr, async rst, and a sat output. It is instantiated REG_NUM-1 times by generate.
- The register array and bypass muxes stay in the top module.
- No $display in RTL; debug observation goes through the bench hierarchy.

Test Plan:
- Reset, then write x5=0xDEADBEEF; next cycle read port0=5, port1=0 -> rdata0=0xDEADBEEF, rdata1=0; wen to x0 with 0x1234 -> x0 still reads 0.
- Same-cycle bypass: wen=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7 -> rdata0=0xA5A5A5A5 in that cycle, rbusy0=0.
- Issue rd=3 twice (cnt=2); one writeback to x3 while raddr0=3 -> rbusy0=1; second writeback -> rbusy0=0 in that cycle, cnt=0 after the edge.
- Saturation, CNT_W=2: issue rd=4 three times -> iss_ready=0. Issue again without wen -> dropped, sb_err=1. Issue with wen to x4 same cycle -> accepted, cnt stays 3.
- Flush with cnt[9]=2 and wen to x9 with 0x55 -> all counters 0 after the edge, x9=0x55, sb_err unchanged. A later wen to x9 -> sb_err=1.
- Assert rst asynchronously between edges after populating x1..x31 -> all reads 0 and rbusy=0 immediately; sb_err=0.
